// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions for the NES system slice.
//   dma_state_t   : sprite DMA controller states
//   DMA_REG_ADDR  : CPU write address that starts an OAM DMA ($4014)
//   OAM_DATA_ADDR : PPU OAM data port ($2004), also used by the PPU register decoder
package nes_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/sprite_dma_if.sv
// CPU-side / system-bus-side signal bundle for the sprite DMA controller.
//   i_clk_en      : CPU-rate clock enable
//   i_cpu_rw      : core rw (1 = read)
//   i_cpu_address : core address
//   i_cpu_data    : core write data
//   i_data        : system bus read data
//   o_cpu_clk_en  : clock enable routed back to the core
//   o_rw          : system bus rw
//   o_address     : system bus address
//   o_data        : system bus write data
//   o_active      : DMA owns the bus
// Modport master is the DMA block; modport slave is the surrounding system.
interface sprite_dma_if;

   logic        i_clk_en;
   logic        i_cpu_rw;
   logic [15:0] i_cpu_address;
   logic [7:0]  i_cpu_data;
   logic [7:0]  i_data;
   logic        o_cpu_clk_en;
   logic        o_rw;
   logic [15:0] o_address;
   logic [7:0]  o_data;
   logic        o_active;

   modport master (
      input  i_clk_en,
      input  i_cpu_rw,
      input  i_cpu_address,
      input  i_cpu_data,
      input  i_data,
      output o_cpu_clk_en,
      output o_rw,
      output o_address,
      output o_data,
      output o_active
   );

   modport slave (
      output i_clk_en,
      output i_cpu_rw,
      output i_cpu_address,
      output i_cpu_data,
      output i_data,
      input  o_cpu_clk_en,
      input  o_rw,
      input  o_address,
      input  o_data,
      input  o_active
   );

endinterface

// File: rtl/sprite_dma.sv
// OAM sprite DMA controller. Sits between the 6502 core and the system bus.
// Snoops CPU writes to DMA_REG_ADDR; on a hit it freezes the core through
// o_cpu_clk_en and copies page {r_page,00..FF} to OAM_DATA_ADDR, one READ and
// one WRITE per byte, then returns the bus to the core.
// Ports:
//   i_clk     : system clock
//   i_reset_n : asynchronous active-low reset
//   bus       : sprite_dma_if master modport (core side in, bus side out)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | core owns the bus; outputs mirror i_cpu_*; watch for $4014 write
// HALT  | first frozen cycle; dummy read of the core's current address
// ALIGN | extra dummy read so that READ always lands on even parity
// READ  | read {r_page, r_index}; latch the returned byte
// WRITE | write the latched byte to OAM data port; advance r_index
module sprite_dma
   import nes_bus_pkg::*;
#(
   parameter logic [15:0] P_DMA_REG_ADDR  = DMA_REG_ADDR,
   parameter logic [15:0] P_OAM_DATA_ADDR = OAM_DATA_ADDR
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   sprite_dma_if.master bus
);

   dma_state_t  state, state_nxt;
   logic [7:0]  r_page, page_nxt;
   logic [7:0]  r_index, index_nxt;
   logic [7:0]  r_latch, latch_nxt;
   logic        r_odd;

   logic        rw_c;
   logic [15:0] address_c;
   logic [7:0]  data_c;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state   <= ST_IDLE;
         r_page  <= 8'h00;
         r_index <= 8'h00;
         r_latch <= 8'h00;
         r_odd   <= 1'b0;
      end else if (bus.i_clk_en) begin
         state   <= state_nxt;
         r_page  <= page_nxt;
         r_index <= index_nxt;
         r_latch <= latch_nxt;
         r_odd   <= ~r_odd;
      end
   end

   always_comb begin
      state_nxt = state;
      page_nxt  = r_page;
      index_nxt = r_index;
      latch_nxt = r_latch;
      rw_c      = 1'b1;
      address_c = bus.i_cpu_address;
      data_c    = r_latch;

      case (state)
         ST_IDLE: begin
            rw_c      = bus.i_cpu_rw;
            address_c = bus.i_cpu_address;
            data_c    = bus.i_cpu_data;
            if (!bus.i_cpu_rw && (bus.i_cpu_address == P_DMA_REG_ADDR)) begin
               page_nxt  = bus.i_cpu_data;
               index_nxt = 8'h00;
               state_nxt = ST_HALT;
            end
         end
         ST_HALT: begin
            // HALT with odd parity means the following cycle is already even.
            state_nxt = r_odd ? ST_READ : ST_ALIGN;
         end
         ST_ALIGN: begin
            state_nxt = ST_READ;
         end
         ST_READ: begin
            address_c = {r_page, r_index};
            latch_nxt = bus.i_data;
            state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            rw_c      = 1'b0;
            address_c = P_OAM_DATA_ADDR;
            index_nxt = r_index + 8'd1;
            state_nxt = (r_index == 8'hFF) ? ST_IDLE : ST_READ;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.o_rw         = rw_c;
   assign bus.o_address    = address_c;
   assign bus.o_data       = data_c;
   assign bus.o_active     = (state != ST_IDLE);
   assign bus.o_cpu_clk_en = bus.i_clk_en & (state == ST_IDLE);

endmodule

// File: tb/tb_sprite_dma.sv
module tb_sprite_dma;

   typedef struct {
      logic        rw;
      logic [15:0] addr;
      logic [7:0]  data;
      logic        chk_data;
   } bus_ev_t;

   logic clk;
   logic rst_n;
   logic en_mode;
   int   en_cnt;
   logic par;
   logic last_edge_en;

   bus_ev_t exp_q[$];

   int checks;
   int errors;
   int halt_cnt;
   int last_halt;

   logic        have_prev;
   logic        prev_active;
   logic        prev_rw;
   logic [15:0] prev_addr;
   logic [7:0]  prev_data;

   sprite_dma_if bus();

   sprite_dma dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   // Memory model: byte at offset k of any page is k ^ $5A.
   assign bus.i_data = bus.o_address[7:0] ^ 8'h5A;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (en_mode) begin
         en_cnt = en_cnt + 1;
         bus.i_clk_en = ((en_cnt % 3) == 0);
      end else begin
         bus.i_clk_en = 1'b1;
      end
   end

   // Independent parity tracker: number of enabled edges since reset, mod 2.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) par <= 1'b0;
      else if (bus.i_clk_en) par <= ~par;
   end

   always @(posedge clk) last_edge_en <= bus.i_clk_en;

   // Monitor / scoreboard
   always @(negedge clk) begin
      bus_ev_t e;
      if (!rst_n) begin
         halt_cnt  = 0;
         have_prev = 1'b0;
      end else begin
         checks = checks + 1;
         if (bus.o_cpu_clk_en !== (bus.i_clk_en & ~bus.o_active)) begin
            errors = errors + 1;
            $display("FAIL cpu_clk_en: got %b want %b (active=%b)", bus.o_cpu_clk_en,
                     bus.i_clk_en & ~bus.o_active, bus.o_active);
         end
         if (have_prev && prev_active && bus.o_active && !last_edge_en) begin
            checks = checks + 1;
            if (bus.o_rw !== prev_rw || bus.o_address !== prev_addr || bus.o_data !== prev_data) begin
               errors = errors + 1;
               $display("FAIL hold_disabled: got rw=%b a=%h d=%h want rw=%b a=%h d=%h",
                        bus.o_rw, bus.o_address, bus.o_data, prev_rw, prev_addr, prev_data);
            end
         end
         if (bus.i_clk_en) begin
            if (bus.o_active) begin
               halt_cnt = halt_cnt + 1;
               checks = checks + 1;
               if (exp_q.size() == 0) begin
                  errors = errors + 1;
                  $display("FAIL unexpected_dma_cycle: got rw=%b a=%h want no DMA cycle",
                           bus.o_rw, bus.o_address);
               end else begin
                  e = exp_q.pop_front();
                  if (bus.o_rw !== e.rw || bus.o_address !== e.addr ||
                      (e.chk_data && bus.o_data !== e.data)) begin
                     errors = errors + 1;
                     $display("FAIL dma_cycle: got rw=%b a=%h d=%h want rw=%b a=%h d=%h",
                              bus.o_rw, bus.o_address, bus.o_data, e.rw, e.addr, e.data);
                  end
               end
            end else begin
               checks = checks + 1;
               if (bus.o_rw !== bus.i_cpu_rw || bus.o_address !== bus.i_cpu_address ||
                   bus.o_data !== bus.i_cpu_data) begin
                  errors = errors + 1;
                  $display("FAIL passthrough: got rw=%b a=%h d=%h want rw=%b a=%h d=%h",
                           bus.o_rw, bus.o_address, bus.o_data,
                           bus.i_cpu_rw, bus.i_cpu_address, bus.i_cpu_data);
               end
               if (halt_cnt != 0) begin
                  last_halt = halt_cnt;
                  halt_cnt  = 0;
               end
            end
         end
         prev_active = bus.o_active;
         prev_rw     = bus.o_rw;
         prev_addr   = bus.o_address;
         prev_data   = bus.o_data;
         have_prev   = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // One core bus cycle: present it, wait for an enabled edge.
   task automatic cpu_op(input logic rw, input logic [15:0] addr, input logic [7:0] data);
      bit done;
      bus.i_cpu_rw      = rw;
      bus.i_cpu_address = addr;
      bus.i_cpu_data    = data;
      done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         if (bus.i_clk_en) begin
            done = 1'b1;
            break;
         end
      end
      #1;
      chk("cpu_op_enabled_edge", {31'd0, done}, 32'd1);
   endtask

   // halt_par: 0 = HALT must have r_odd=0, 1 = r_odd=1, 2 = take whatever comes.
   task automatic trigger(input logic [7:0] page, input int halt_par, output int exp_halt);
      bus_ev_t e;
      logic align;
      if (halt_par == 0 && par != 1'b1) cpu_op(1'b1, 16'h8000, 8'h00);
      if (halt_par == 1 && par != 1'b0) cpu_op(1'b1, 16'h8000, 8'h00);
      // The trigger cycle has parity par; HALT has the opposite.
      align    = (par == 1'b1);
      exp_halt = align ? 514 : 513;
      e = '{rw: 1'b1, addr: 16'h8123, data: 8'h00, chk_data: 1'b0};
      exp_q.push_back(e);
      if (align) exp_q.push_back(e);
      for (int k = 0; k < 256; k++) begin
         e = '{rw: 1'b1, addr: {page, k[7:0]}, data: 8'h00, chk_data: 1'b0};
         exp_q.push_back(e);
         e = '{rw: 1'b0, addr: 16'h2004, data: k[7:0] ^ 8'h5A, chk_data: 1'b1};
         exp_q.push_back(e);
      end
      cpu_op(1'b0, 16'h4014, page);
      // Core's next cycle (frozen during DMA): an opcode fetch at $8123.
      bus.i_cpu_rw      = 1'b1;
      bus.i_cpu_address = 16'h8123;
      bus.i_cpu_data    = 8'h00;
   endtask

   task automatic wait_done(input string name, input int exp_halt);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #2;
         if (!bus.o_active) begin
            done = 1'b1;
            break;
         end
      end
      chk({name, "_finished"}, {31'd0, done}, 32'd1);
      cpu_op(1'b1, 16'h8124, 8'h00);
      cpu_op(1'b1, 16'h8125, 8'h00);
      chk({name, "_halt_len"}, last_halt, exp_halt);
      chk({name, "_queue_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  eh;
      bit  found;
      checks = 0;
      errors = 0;
      halt_cnt = 0;
      last_halt = 0;
      have_prev = 1'b0;
      en_mode = 1'b0;
      en_cnt = 0;
      rst_n = 1'b0;
      bus.i_clk_en      = 1'b1;
      bus.i_cpu_rw      = 1'b1;
      bus.i_cpu_address = 16'h8000;
      bus.i_cpu_data    = 8'h00;
      #1;
      chk("reset_active", {31'd0, bus.o_active}, 32'd0);
      chk("reset_addr", {16'd0, bus.o_address}, 32'h8000);
      chk("reset_rw", {31'd0, bus.o_rw}, 32'd1);
      chk("reset_cpu_clk_en", {31'd0, bus.o_cpu_clk_en}, 32'd1);
      bus.i_cpu_rw = 1'b0;
      bus.i_cpu_address = 16'h1234;
      bus.i_cpu_data = 8'hC3;
      #1;
      chk("reset_pass_wr", {15'd0, bus.o_rw, bus.o_address}, {15'd0, 1'b0, 16'h1234});
      chk("reset_pass_data", {24'd0, bus.o_data}, 32'hC3);
      #10 rst_n = 1'b1;

      // Passthrough: write $4015, read $4014 -> no transfer.
      cpu_op(1'b0, 16'h4015, 8'hAA);
      cpu_op(1'b1, 16'h4014, 8'h55);
      cpu_op(1'b0, 16'h0300, 8'h02);
      cpu_op(1'b1, 16'h8000, 8'h00);
      chk("passthrough_idle", {31'd0, bus.o_active}, 32'd0);

      // Even-parity trigger: HALT at r_odd=0, ALIGN present, 514 halted.
      trigger(8'h02, 0, eh);
      chk("even_exp_halt", eh, 514);
      wait_done("even", eh);

      // Odd-parity trigger: HALT at r_odd=1, no ALIGN, 513 halted.
      trigger(8'h02, 1, eh);
      chk("odd_exp_halt", eh, 513);
      wait_done("odd", eh);

      // Clock enable 1-in-3 during a transfer.
      en_mode = 1'b1;
      trigger(8'h02, 2, eh);
      wait_done("clk_en_toggle", eh);
      en_mode = 1'b0;
      cpu_op(1'b1, 16'h8000, 8'h00);

      // Reset at WRITE of index $10.
      trigger(8'h05, 2, eh);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #2;
         if (bus.o_active && !bus.o_rw && bus.o_address == 16'h2004 &&
             bus.o_data == (8'h10 ^ 8'h5A)) begin
            found = 1'b1;
            break;
         end
      end
      chk("abort_reached_write_10", {31'd0, found}, 32'd1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("abort_active_low", {31'd0, bus.o_active}, 32'd0);
      chk("abort_pass_addr", {16'd0, bus.o_address}, 32'h8123);
      chk("abort_cpu_clk_en", {31'd0, bus.o_cpu_clk_en}, 32'd1);
      @(negedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("abort_resume", {30'd0, bus.o_cpu_clk_en, bus.o_active}, 32'd2);
      cpu_op(1'b1, 16'h8000, 8'h00);
      trigger(8'h03, 2, eh);
      wait_done("restart", eh);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
